// File: rtl/aes_axis_block_packer.sv
// -----------------------------------------------------------------------------
// aes_axis_block_packer
//
// Packs an AXI-Stream byte-oriented input into fixed-size cipher blocks.
// Beats are placed MSB-first: beat k of a block occupies
// bits [BLOCK_W-1-k*IN_W -: IN_W]. A message ending part-way through a block
// is padded with zeros (PAD_MODE=0) or PKCS#7 bytes (PAD_MODE=1). With PKCS#7,
// a message that ends exactly on a block boundary is followed by one extra
// block in which every byte equals BLOCK_W/8.
//
// Parameters
//   IN_W     input beat width in bits (multiple of 8, divides BLOCK_W)
//   BLOCK_W  output block width in bits
//   PAD_MODE 0 = zero padding, 1 = PKCS#7 padding
//
// Ports
//   clk_i          clock, all logic on its rising edge
//   rst_i          synchronous active-high reset
//   axis_tdata_i   input beat data
//   axis_tvalid_i  input beat valid
//   axis_tready_o  input beat accepted when high together with axis_tvalid_i
//   axis_tlast_i   input beat is the final beat of a message
//   blk_data_o     assembled block
//   blk_valid_o    blk_data_o holds a block
//   blk_ready_i    downstream accepts the block when high with blk_valid_o
//   blk_last_o     block is the final block of a message
//   blk_cnt_o      blocks handed off since reset (wraps)
// -----------------------------------------------------------------------------
module aes_axis_block_packer #(
  parameter int IN_W     = 8,
  parameter int BLOCK_W  = 128,
  parameter int PAD_MODE = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IN_W-1:0]    axis_tdata_i,
  input  logic               axis_tvalid_i,
  output logic               axis_tready_o,
  input  logic               axis_tlast_i,
  output logic [BLOCK_W-1:0] blk_data_o,
  output logic               blk_valid_o,
  input  logic               blk_ready_i,
  output logic               blk_last_o,
  output logic [31:0]        blk_cnt_o
);

  localparam int N              = BLOCK_W / IN_W;
  localparam int CNT_W          = (N > 1) ? $clog2(N) : 1;
  localparam int BYTES_PER_BEAT = IN_W / 8;
  localparam int BLOCK_BYTES    = BLOCK_W / 8;

  localparam logic [CNT_W-1:0]   LAST_SLOT = CNT_W'(N - 1);
  // Stand-alone PKCS#7 block: every byte carries the block length in bytes.
  localparam logic [BLOCK_W-1:0] PAD_BLOCK = {BLOCK_BYTES{8'(BLOCK_BYTES)}};

  typedef enum logic [1:0] {
    ST_FILL,
    ST_HOLD,
    ST_PAD
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q;
  logic [BLOCK_W-1:0] buf_q, buf_d;
  logic               last_q;
  logic               pad_pend_q;
  logic [31:0]        blk_cnt_q;

  logic               beat_acc;
  logic               beat_done;
  logic               full_slot;
  logic               blk_hs;
  logic [7:0]         pad_byte;
  logic [IN_W-1:0]    pad_beat;

  assign full_slot = (cnt_q == LAST_SLOT);
  assign beat_acc  = axis_tready_o & axis_tvalid_i;
  assign beat_done = beat_acc & (full_slot | axis_tlast_i);
  assign blk_hs    = blk_valid_o & blk_ready_i;
  assign blk_cnt_o = blk_cnt_q;

  // Pad byte for a short final block: number of bytes left unfilled after
  // the current slot. Only meaningful when the current beat carries tlast.
  // NOTE: every signal assigned in always_comb gets a default first so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pad_byte = '0;
    if (PAD_MODE == 1) begin
      pad_byte = 8'((N - 1 - int'(cnt_q)) * BYTES_PER_BEAT);
    end
  end

  assign pad_beat = {BYTES_PER_BEAT{pad_byte}};

  // Write the accepted beat into its slot. On tlast, also overwrite every
  // later slot with padding so stale bytes of an earlier block never leak.
  // NOTE: combinational blocks use blocking '=' so later statements see the
  // updated value; registers below use non-blocking '<=' to avoid races.
  always_comb begin
    buf_d = buf_q;
    if (beat_acc) begin
      for (int j = 0; j < N; j++) begin
        if (j == int'(cnt_q)) begin
          buf_d[BLOCK_W-1-j*IN_W -: IN_W] = axis_tdata_i;
        end else if (axis_tlast_i && (j > int'(cnt_q))) begin
          buf_d[BLOCK_W-1-j*IN_W -: IN_W] = pad_beat;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL: if (beat_done) state_d = ST_HOLD;
      ST_HOLD: if (blk_hs)    state_d = pad_pend_q ? ST_PAD : ST_FILL;
      ST_PAD:  if (blk_hs)    state_d = ST_FILL;
      default:                state_d = ST_FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    axis_tready_o = 1'b0;
    blk_valid_o   = 1'b0;
    blk_last_o    = 1'b0;
    blk_data_o    = buf_q;
    unique case (state_q)
      // Gate with rst_i so no beat is taken during the reset cycle.
      ST_FILL: axis_tready_o = ~rst_i;
      ST_HOLD: begin
        blk_valid_o = 1'b1;
        blk_last_o  = last_q;
      end
      ST_PAD: begin
        blk_valid_o = 1'b1;
        blk_last_o  = 1'b1;
        blk_data_o  = PAD_BLOCK;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: slot counter, block buffer, per-block flags, handoff counter
  // ---------------------------------------------------------------------------
  // NOTE: the block buffer is reset on purpose: blk_data_o must read zero
  // after reset. Storage that is never observed before being written would
  // normally be left without reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      buf_q      <= '0;
      last_q     <= 1'b0;
      pad_pend_q <= 1'b0;
      blk_cnt_q  <= '0;
    end else begin
      buf_q <= buf_d;

      if (beat_acc) begin
        if (beat_done) begin
          // A full final block under PKCS#7 is not the last one: the
          // stand-alone pad block follows it.
          last_q     <= axis_tlast_i & ~(full_slot & (PAD_MODE == 1));
          pad_pend_q <= axis_tlast_i & full_slot & (PAD_MODE == 1);
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      if (blk_hs) begin
        blk_cnt_q <= blk_cnt_q + 32'd1;
        if (state_q == ST_HOLD) cnt_q      <= '0;
        if (state_q == ST_PAD)  pad_pend_q <= 1'b0;
      end
    end
  end

endmodule
